// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock parametrised FIFO used as elastic buffering between DSP
//   pipeline stages. It has programmable almost-full and almost-empty
//   thresholds, an occupancy count, an optional first-word-fall-through
//   (FWFT) read mode, a synchronous flush, and one-cycle error pulses for
//   overflow and underflow.
//
// Parameters
//   DW         data width in bits (>= 1)
//   DEPTH      number of storage entries; a power of 2, >= 2
//   AW         address width, derived from DEPTH; do not override
//   AF_THRESH  o_afull is high when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  o_aempty is high when count <= AE_THRESH (0..DEPTH-1)
//   FWFT       0: o_rdata updates one cycle after an accepted read
//              1: o_rdata always shows the head word; i_rd pops it
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   i_clr        synchronous flush (active high); overrides i_wr and i_rd
//   i_wr/i_wdata write request and write data
//   i_rd         read request (in FWFT mode, acknowledges o_rdata)
//   o_rdata      read data
//   o_full       count == DEPTH
//   o_afull      count >= AF_THRESH
//   o_empty      count == 0
//   o_aempty     count <= AE_THRESH
//   o_count      occupancy, 0..DEPTH
//   o_overflow   one-cycle pulse: a write was attempted while full
//   o_underflow  one-cycle pulse: a read was attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DW        = 24,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_full,
  output logic          o_afull,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_empty,
  output logic          o_aempty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic          o_underflow
);

  // Elaboration-time parameter checks
  if (DW < 1) begin : g_bad_dw
    $error("sync_fifo: DW must be >= 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH must be in 0..DEPTH-1");
  end

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW + 1)'(AE_THRESH);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  logic [DW-1:0] mem [DEPTH];

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [AW-1:0] wr_addr, rd_addr;
  logic          full, empty;
  logic          wr_ok, rd_ok;

  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  // The flags are decoded straight from the registered count. That way they
  // never lag the count and they take their reset values as soon as the
  // count is reset.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign o_full      = full;
  assign o_empty     = empty;
  assign o_afull     = (count_q >= AF_C);
  assign o_aempty    = (count_q <= AE_C);
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

  // Flush wins over both requests and suppresses the error pulses.
  assign wr_ok = i_wr & ~full  & ~i_clr;
  assign rd_ok = i_rd & ~empty & ~i_clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = i_wr & full  & ~i_clr;
    underflow_d = i_rd & empty & ~i_clr;
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ONE_C;
      if (rd_ok) rd_ptr_d = rd_ptr_q + ONE_C;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array. It is not reset, so its contents are only meaningful
  // for entries between the read and write pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= i_wdata;
  end

  if (FWFT == 0) begin : g_std_read
    logic [DW-1:0] rdata_q, rdata_d;

    // Registered read. The value holds between accepted reads and across
    // a flush.
    always_comb begin
      rdata_d = rdata_q;
      if (rd_ok) rdata_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign o_rdata = rdata_q;
  end else begin : g_fwft_read
    // The head word is shown continuously. The output is forced to zero
    // while empty so that it reads as zero after a reset or flush, and
    // never shows stale array contents.
    assign o_rdata = empty ? '0 : mem[rd_addr];
  end

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//   Two instances, one standard-read (FWFT=0) and one fall-through (FWFT=1),
//   are driven with the same inputs. Both are checked against a queue-based
//   reference model that is updated once per clock.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_clr, i_wr, i_rd;
  logic [DW-1:0] i_wdata;

  logic          s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
  logic [DW-1:0] s_rdata;
  logic [3:0]    s_count;
  logic          f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
  logic [DW-1:0] f_rdata;
  logic [3:0]    f_count;

  always #5 clk = ~clk;

  sync_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_wr(i_wr), .i_wdata(i_wdata),
    .o_full(s_full), .o_afull(s_afull), .i_rd(i_rd), .o_rdata(s_rdata),
    .o_empty(s_empty), .o_aempty(s_aempty), .o_count(s_count),
    .o_overflow(s_ovf), .o_underflow(s_unf)
  );

  sync_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_wr(i_wr), .i_wdata(i_wdata),
    .o_full(f_full), .o_afull(f_afull), .i_rd(i_rd), .o_rdata(f_rdata),
    .o_empty(f_empty), .o_aempty(f_aempty), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rdata;      // last popped word (standard-read mode)
  logic          m_ovf, m_unf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int cnt;
    logic [DW-1:0] head;
    cnt  = mq.size();
    head = (cnt != 0) ? mq[0] : '0;
    chk({ph, ".count"},  {28'd0, s_count},  cnt);
    chk({ph, ".full"},   {31'd0, s_full},   {31'd0, cnt == DEPTH});
    chk({ph, ".afull"},  {31'd0, s_afull},  {31'd0, cnt >= AF});
    chk({ph, ".empty"},  {31'd0, s_empty},  {31'd0, cnt == 0});
    chk({ph, ".aempty"}, {31'd0, s_aempty}, {31'd0, cnt <= AE});
    chk({ph, ".ovf"},    {31'd0, s_ovf},    {31'd0, m_ovf});
    chk({ph, ".unf"},    {31'd0, s_unf},    {31'd0, m_unf});
    chk({ph, ".rdata"},  {24'd0, s_rdata},  {24'd0, m_rdata});
    chk({ph, ".f_count"}, {28'd0, f_count}, cnt);
    chk({ph, ".f_empty"}, {31'd0, f_empty}, {31'd0, cnt == 0});
    chk({ph, ".f_full"},  {31'd0, f_full},  {31'd0, cnt == DEPTH});
    chk({ph, ".f_ovf"},   {31'd0, f_ovf},   {31'd0, m_ovf});
    chk({ph, ".f_unf"},   {31'd0, f_unf},   {31'd0, m_unf});
    chk({ph, ".f_rdata"}, {24'd0, f_rdata}, {24'd0, head});
    $display("[%0t] %s wr=%0b rd=%0b clr=%0b wdata=%02h count=%0d rdata=%02h frdata=%02h",
             $time, ph, i_wr, i_rd, i_clr, i_wdata, s_count, s_rdata, f_rdata);
  endtask

  // One clock with the given inputs; the model applies the FIFO rules to the
  // state it held before the edge, and outputs are sampled 1 ns after it.
  task automatic cycle(input string ph, input logic wr, input logic rd,
                       input logic clr, input logic [DW-1:0] wd);
    int  cnt;
    logic full, empty;
    i_wr = wr; i_rd = rd; i_clr = clr; i_wdata = wd;
    @(posedge clk);
    cnt   = mq.size();
    full  = (cnt == DEPTH);
    empty = (cnt == 0);
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = wr & full;
      m_unf = rd & empty;
      if (rd && !empty) m_rdata = mq.pop_front();
      if (wr && !full)  mq.push_back(wd);
    end
    #1;
    check_all(ph);
  endtask

  initial begin
    logic [DW-1:0] d;
    rst_n = 1'b0; i_clr = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_wdata = '0;
    m_rdata = '0; m_ovf = 1'b0; m_unf = 1'b0;
    #2;
    check_all("reset");
    #10 rst_n = 1'b1;

    // Fill to full, one overflow attempt, then drain in order
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 1'b0, 1'b0, DW'(i));
    cycle("ovf", 1'b1, 1'b0, 1'b0, 8'hFF);
    cycle("ovf_end", 1'b0, 1'b0, 1'b0, 8'h00);
    cycle("full_wr_rd", 1'b1, 1'b1, 1'b0, 8'hEE);
    cycle("refill", 1'b1, 1'b0, 1'b0, 8'h09);
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 1'b1, 1'b0, 8'h00);

    // Underflow on empty, then a simultaneous read and write while empty
    cycle("unf", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("unf_end", 1'b0, 1'b0, 1'b0, 8'h00);
    cycle("empty_wr_rd", 1'b1, 1'b1, 1'b0, 8'h3C);
    cycle("pop", 1'b0, 1'b1, 1'b0, 8'h00);

    // Preload 4, then steady streaming with the pointers wrapping
    for (int i = 0; i < 4; i++) cycle("preload", 1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
    for (int i = 4; i < 24; i++) cycle("stream", 1'b1, 1'b1, 1'b0, DW'(8'h40 + i));
    for (int i = 0; i < 4; i++) cycle("stream_drain", 1'b0, 1'b1, 1'b0, 8'h00);

    // Fall-through: a word is visible without i_rd; i_rd pops it
    cycle("fwft_wr", 1'b1, 1'b0, 1'b0, 8'hA5);
    cycle("fwft_hold", 1'b0, 1'b0, 1'b0, 8'h00);
    cycle("fwft_pop", 1'b0, 1'b1, 1'b0, 8'h00);

    // Flush at count 5 while a write is requested
    for (int i = 0; i < 5; i++) cycle("pre_clr", 1'b1, 1'b0, 1'b0, DW'(8'h70 + i));
    cycle("clr", 1'b1, 1'b1, 1'b0 | 1'b1, 8'h99);
    cycle("post_clr", 1'b0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 1'b0, 1'b0, DW'(8'h80 + i));
    i_wr = 1'b0; i_rd = 1'b0; i_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mq.delete(); m_rdata = '0; m_ovf = 1'b0; m_unf = 1'b0;
    check_all("async_rst");
    #1 rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      d = DW'($urandom);
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
